// File: rtl/drive_pkg.sv
// Shared types for the drive sequencer: FSM states, gear codes and the gear-to-duty map.
// The same duty_of() map feeds both motor channels.
package drive_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_FWD,
    ST_REV_WAIT,
    ST_REV
  } state_t;

  localparam logic [2:0] STOP = 3'd0;
  localparam logic [2:0] G1   = 3'd1;
  localparam logic [2:0] G2   = 3'd2;
  localparam logic [2:0] G3   = 3'd3;
  localparam logic [2:0] G4   = 3'd4;
  localparam logic [2:0] G5   = 3'd5;
  localparam logic [2:0] RG   = 3'd6;

  // Forward gear n maps to n*51, so top gear is full scale (255).
  function automatic logic [7:0] duty_of(input logic [2:0] lvl);
    logic [7:0] d;
    case (lvl)
      G1:      d = 8'd51;
      G2:      d = 8'd102;
      G3:      d = 8'd153;
      G4:      d = 8'd204;
      G5:      d = 8'd255;
      default: d = 8'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Two PWM channels sharing one free-running counter; pwm = (cnt < duty).
// Outputs are registered, so there is 1 clk from a duty change to the pin. No backpressure.
module pwm_gen #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_l_i,
  input  logic [PWM_BITS-1:0] duty_r_i,
  output logic                pwm_l_o,
  output logic                pwm_r_o
);

  logic [PWM_BITS-1:0] cnt_q;
  logic                pwm_l_q;
  logic                pwm_r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pwm_l_q <= 1'b0;
      pwm_r_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
      pwm_l_q <= (cnt_q < duty_l_i);
      pwm_r_q <= (cnt_q < duty_r_i);
    end
  end

  assign pwm_l_o = pwm_l_q;
  assign pwm_r_o = pwm_r_q;

endmodule

// File: rtl/drive_seq_ctrl.sv
// Drive sequencer: tick prescaler, gear FSM and steering duty split feeding pwm_gen.
// Gear changes land on tick edges; duty follows gear_lvl by 1 clk and the PWM pins by 2. No backpressure.
module drive_seq_ctrl
  import drive_pkg::*;
#(
  parameter int unsigned         TICK_DIV  = 50_000_000,
  parameter int unsigned         PWM_BITS  = 8,
  parameter int unsigned         MAX_GEAR  = 5,
  parameter int unsigned         TURN_MAX  = 3,
  parameter int unsigned         REV_DWELL = 2,
  parameter logic [PWM_BITS-1:0] REV_DUTY  = 8'd64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  input  logic       acc,
  input  logic       brake,
  input  logic       gear,
  input  logic       l,
  input  logic       r,
  output logic [2:0] gear_lvl,
  output logic       dir,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       tick_o,
  output logic       shift_evt
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [2:0]       MAX_LVL    = 3'(MAX_GEAR);
  localparam logic [2:0]       TURN_LVL   = 3'(TURN_MAX);
  localparam logic [3:0]       DWELL_LAST = 4'(REV_DWELL - 1);

  logic [PRE_W-1:0]    pre_q;
  logic                tick;
  state_t              state_q, state_d;
  logic [2:0]          lvl_q, lvl_d;
  logic [3:0]          dwell_q, dwell_d;
  logic                dir_q, dir_d;
  logic                shift_q;
  logic                steer;
  logic [PWM_BITS-1:0] base_duty;
  logic [PWM_BITS-1:0] duty_l_d, duty_r_d, duty_l_q, duty_r_q;

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // key=0 overrides every state; reverse only engages from standstill via the dwell.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    dwell_d = dwell_q;
    if (!key) begin
      state_d = ST_OFF;
      lvl_d   = STOP;
      dwell_d = '0;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_IDLE;
        ST_IDLE: begin
          lvl_d = STOP;
          if (tick) begin
            if (gear) begin
              state_d = ST_REV_WAIT;
            end else if (acc && !brake) begin
              state_d = ST_FWD;
              lvl_d   = G1;
            end
          end
        end
        ST_FWD: begin
          if (tick) begin
            if (brake || gear) begin
              if (lvl_q <= G2) begin
                lvl_d   = STOP;
                state_d = ST_IDLE;
              end else begin
                lvl_d = lvl_q - 3'd2;
              end
            end else if (acc) begin
              if (lvl_q < MAX_LVL) lvl_d = lvl_q + 3'd1;
            end else if (lvl_q > G1) begin
              lvl_d = lvl_q - 3'd1;
            end
          end
        end
        ST_REV_WAIT: begin
          lvl_d = STOP;
          if (!gear) begin
            state_d = ST_IDLE;
            dwell_d = '0;
          end else if (tick) begin
            if (dwell_q == DWELL_LAST) begin
              state_d = ST_REV;
              lvl_d   = RG;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + 4'd1;
            end
          end
        end
        ST_REV: begin
          if (!gear) begin
            state_d = ST_IDLE;
            lvl_d   = STOP;
          end
        end
        default: begin
          state_d = ST_OFF;
          lvl_d   = STOP;
          dwell_d = '0;
        end
      endcase
    end
  end

  assign dir_d = (state_d == ST_REV);

  // Duty is derived from the registered gear, hence the 1-clk lag behind gear_lvl.
  always_comb begin
    base_duty = '0;
    if (key) begin
      if (state_q == ST_FWD) begin
        base_duty = PWM_BITS'(duty_of(lvl_q));
      end else if (state_q == ST_REV && !brake) begin
        base_duty = REV_DUTY;
      end
    end
    steer    = (l ^ r) && ((state_q == ST_REV) || (state_q == ST_FWD && lvl_q <= TURN_LVL));
    duty_l_d = (steer && l) ? (base_duty >> 1) : base_duty;
    duty_r_d = (steer && r) ? (base_duty >> 1) : base_duty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_OFF;
      lvl_q    <= STOP;
      dwell_q  <= '0;
      dir_q    <= 1'b0;
      shift_q  <= 1'b0;
      duty_l_q <= '0;
      duty_r_q <= '0;
    end else begin
      state_q  <= state_d;
      lvl_q    <= lvl_d;
      dwell_q  <= dwell_d;
      dir_q    <= dir_d;
      shift_q  <= (lvl_d != lvl_q);
      duty_l_q <= duty_l_d;
      duty_r_q <= duty_r_d;
    end
  end

  pwm_gen #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .duty_l_i(duty_l_q),
    .duty_r_i(duty_r_q),
    .pwm_l_o (pwm_l),
    .pwm_r_o (pwm_r)
  );

  assign gear_lvl  = lvl_q;
  assign dir       = dir_q;
  assign tick_o    = tick;
  assign shift_evt = shift_q;

endmodule
